decode_stage: RTL and testbench

- Y86-64 pipeline decode/write-back stage. Sits directly downstream of the fetch stage and consumes its D_ pipeline-register outputs.
- Holds the 15-entry architectural register file, computes source/destination register IDs, and forwards operands from the E/M/W stages.
- Owns the E pipeline register that feeds execute. Register-file writes come from the W stage.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Y86-64 decode/write-back: register file, src/dst IDs, operand forwarding, E pipeline register; 1-cycle D->E, d_srcA/B combinational.
// No backpressure: E never stalls, hazard control squashes via E_bubble. Forwarding chain enabled by `define DECODE_FWD_EN.
module decode_stage #(
    parameter int         WORD   = 64,
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      D_stat,
    input  logic [3:0]      D_icode,
    input  logic [3:0]      D_ifun,
    input  logic [3:0]      D_rA,
    input  logic [3:0]      D_rB,
    input  logic [WORD-1:0] D_valC,
    input  logic [WORD-1:0] D_valP,
    input  logic            E_bubble,
    input  logic [3:0]      e_dstE,
    input  logic [WORD-1:0] e_valE,
    input  logic [3:0]      M_dstE,
    input  logic [WORD-1:0] M_valE,
    input  logic [3:0]      M_dstM,
    input  logic [WORD-1:0] m_valM,
    input  logic [3:0]      W_dstE,
    input  logic [WORD-1:0] W_valE,
    input  logic [3:0]      W_dstM,
    input  logic [WORD-1:0] W_valM,
    output logic [3:0]      d_srcA,
    output logic [3:0]      d_srcB,
    output logic [3:0]      E_stat,
    output logic [3:0]      E_icode,
    output logic [3:0]      E_ifun,
    output logic [WORD-1:0] E_valC,
    output logic [WORD-1:0] E_valA,
    output logic [WORD-1:0] E_valB,
    output logic [3:0]      E_dstE,
    output logic [3:0]      E_dstM,
    output logic [3:0]      E_srcA,
    output logic [3:0]      E_srcB
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [WORD-1:0] valC;
        logic [WORD-1:0] valA;
        logic [WORD-1:0] valB;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
        logic [3:0]      srcA;
        logic [3:0]      srcB;
    } eReg_t;

    logic [3:0]      srcA, srcB, dstE, dstM;
    logic [WORD-1:0] regFile [NREG];
    logic [WORD-1:0] rfA, rfB, fwdA, fwdB, valA;
    eReg_t           eReg, eNext, eNop;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = D_rA;
            I_RET, I_POPQ:                      srcA = RSP_ID;
            default:                            srcA = RNONE;
        endcase
        case (D_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = RSP_ID;
            default:                            srcB = RNONE;
        endcase
        // cmov always names rB here; execute cancels the write when the condition fails
        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          dstE = D_rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     dstE = RSP_ID;
            default:                            dstE = RNONE;
        endcase
        case (D_icode)
            I_MRMOVQ, I_POPQ:                   dstM = D_rA;
            default:                            dstM = RNONE;
        endcase
    end

    assign d_srcA = srcA;
    assign d_srcB = srcB;

    // Asynchronous reads see pre-edge contents; same-cycle W data arrives only via forwarding
    assign rfA = (srcA == RNONE) ? '0 : regFile[srcA];
    assign rfB = (srcB == RNONE) ? '0 : regFile[srcB];

`ifdef DECODE_FWD_EN
    logic [3:0]      fwdId  [5];
    logic [WORD-1:0] fwdVal [5];

    // Index 0 is the youngest producer and has highest priority
    assign fwdId[0] = e_dstE;  assign fwdVal[0] = e_valE;
    assign fwdId[1] = M_dstM;  assign fwdVal[1] = m_valM;
    assign fwdId[2] = M_dstE;  assign fwdVal[2] = M_valE;
    assign fwdId[3] = W_dstM;  assign fwdVal[3] = W_valM;
    assign fwdId[4] = W_dstE;  assign fwdVal[4] = W_valE;

    always_comb begin
        fwdA = rfA;
        fwdB = rfB;
        for (int i = 4; i >= 0; i--) begin
            if (srcA != RNONE && srcA == fwdId[i]) fwdA = fwdVal[i];
            if (srcB != RNONE && srcB == fwdId[i]) fwdB = fwdVal[i];
        end
    end
`else
    logic unusedFwd;
    assign unusedFwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
    assign fwdA = rfA;
    assign fwdB = rfB;
`endif

    assign valA = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : fwdA;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else begin
            if (W_dstE != RNONE) regFile[W_dstE] <= W_valE;
            // Issued second so valM wins when both ports target the same register
            if (W_dstM != RNONE) regFile[W_dstM] <= W_valM;
        end
    end

    always_comb begin
        eNop       = '0;
        eNop.stat  = S_AOK;
        eNop.icode = I_NOP;
        eNop.dstE  = RNONE;
        eNop.dstM  = RNONE;
        eNop.srcA  = RNONE;
        eNop.srcB  = RNONE;

        eNext       = '0;
        eNext.stat  = D_stat;
        eNext.icode = D_icode;
        eNext.ifun  = D_ifun;
        eNext.valC  = D_valC;
        eNext.valA  = valA;
        eNext.valB  = fwdB;
        eNext.dstE  = dstE;
        eNext.dstM  = dstM;
        eNext.srcA  = srcA;
        eNext.srcB  = srcB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eReg <= eNop;
        end else if (E_bubble) begin
            eReg <= eNop;
        end else begin
            eReg <= eNext;
        end
    end

    assign E_stat  = eReg.stat;
    assign E_icode = eReg.icode;
    assign E_ifun  = eReg.ifun;
    assign E_valC  = eReg.valC;
    assign E_valA  = eReg.valA;
    assign E_valB  = eReg.valB;
    assign E_dstE  = eReg.dstE;
    assign E_dstM  = eReg.dstM;
    assign E_srcA  = eReg.srcA;
    assign E_srcB  = eReg.srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  stat, icode, ifun, dstE, dstM, srcA, srcB;
        logic [63:0] valC, valA, valB;
    } eExp_t;

    int          nChecks = 0;
    int          nErr    = 0;
    bit          chkEn   = 0;
    eExp_t       expE;
    logic [63:0] mRegs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mSrcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] mSrcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] mDstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] mDstM(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    // Operand value as seen by decode: youngest in-flight producer first, else architectural state
    function automatic logic [63:0] mRead(input logic [3:0] src);
        logic [3:0]  ids [5];
        logic [63:0] vs  [5];
        if (src == 4'hF) return 64'd0;
        ids = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vs  = '{e_valE, m_valM, M_valE, W_valM, W_valE};
`ifdef DECODE_FWD_EN
        foreach (ids[i]) if (ids[i] == src) return vs[i];
`endif
        return mRegs[src];
    endfunction

    function automatic eExp_t nopE();
        eExp_t e;
        e.stat = 4'h1; e.icode = 4'h1; e.ifun = 4'h0;
        e.valC = 64'd0; e.valA = 64'd0; e.valB = 64'd0;
        e.dstE = 4'hF; e.dstM = 4'hF; e.srcA = 4'hF; e.srcB = 4'hF;
        return e;
    endfunction

    function automatic eExp_t modelE();
        eExp_t e;
        e.stat  = D_stat;
        e.icode = D_icode;
        e.ifun  = D_ifun;
        e.valC  = D_valC;
        e.srcA  = mSrcA(D_icode, D_rA);
        e.srcB  = mSrcB(D_icode, D_rB);
        e.dstE  = mDstE(D_icode, D_rB);
        e.dstM  = mDstM(D_icode, D_rA);
        e.valA  = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : mRead(e.srcA);
        e.valB  = mRead(e.srcB);
        return e;
    endfunction

    always @(negedge clk) begin
        if (chkEn) begin
            chk("E_stat",  {60'd0, E_stat},  {60'd0, expE.stat});
            chk("E_icode", {60'd0, E_icode}, {60'd0, expE.icode});
            chk("E_ifun",  {60'd0, E_ifun},  {60'd0, expE.ifun});
            chk("E_valC",  E_valC, expE.valC);
            chk("E_valA",  E_valA, expE.valA);
            chk("E_valB",  E_valB, expE.valB);
            chk("E_dstE",  {60'd0, E_dstE},  {60'd0, expE.dstE});
            chk("E_dstM",  {60'd0, E_dstM},  {60'd0, expE.dstM});
            chk("E_srcA",  {60'd0, E_srcA},  {60'd0, expE.srcA});
            chk("E_srcB",  {60'd0, E_srcB},  {60'd0, expE.srcB});
            chk("d_srcA",  {60'd0, d_srcA},  {60'd0, mSrcA(D_icode, D_rA)});
            chk("d_srcB",  {60'd0, d_srcB},  {60'd0, mSrcB(D_icode, D_rB)});
        end
    end

    // Model the edge: E loads from pre-edge inputs/state, then the W writes land (valM last)
    task automatic tick();
        eExp_t n;
        n = (rst || E_bubble) ? nopE() : modelE();
        @(posedge clk);
        expE = n;
        if (!rst) begin
            if (W_dstE != 4'hF) mRegs[W_dstE] = W_valE;
            if (W_dstM != 4'hF) mRegs[W_dstM] = W_valM;
        end
        #1;
    endtask

    task automatic idle();
        D_stat = 4'h1; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
        D_valC = 64'd0; D_valP = 64'd0; E_bubble = 1'b0;
        e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        expE = nopE();
        foreach (mRegs[i]) mRegs[i] = 64'd0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        #2;
        doReset();
        chkEn = 1;
        tick();
        tick();
        chk("reset_icode", {60'd0, E_icode}, 64'd1);
        chk("reset_stat",  {60'd0, E_stat},  64'd1);
        chk("reset_dstE",  {60'd0, E_dstE},  64'hF);
        rst = 1'b0;

        // Write-back then read through the register file
        W_dstE = 4'd3; W_valE = 64'd100;
        tick();
        idle();
        D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd5;
        tick();
        chk("wb_valA", E_valA, 64'd100);
        chk("wb_dstE", {60'd0, E_dstE}, 64'd5);

        // Forwarding priority on srcA=2
        idle();
        D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'hF;
        e_dstE = 4'd2; e_valE = 64'd7;
        M_dstE = 4'd2; M_valE = 64'd8;
        W_dstE = 4'd2; W_valE = 64'd9;
        tick();
`ifdef DECODE_FWD_EN
        chk("fwd_e_wins", E_valA, 64'd7);
`else
        chk("nofwd_old_reg", E_valA, 64'd0);
`endif
        e_dstE = 4'hF;
        tick();
`ifdef DECODE_FWD_EN
        chk("fwd_m_wins", E_valA, 64'd8);
`else
        chk("nofwd_reg_written", E_valA, 64'd9);
`endif

        // popq %rsp with both write ports on register 4
        idle();
        D_icode = 4'hB; D_rA = 4'd4;
        W_dstE = 4'd4; W_valE = 64'd40; W_dstM = 4'd4; W_valM = 64'd55;
        tick();
        idle();
        D_icode = 4'hA; D_rA = 4'd4;
        tick();
        chk("popq_rsp_valM", E_valA, 64'd55);

        // call
        idle();
        D_icode = 4'h8; D_valP = 64'd42;
        tick();
        chk("call_valA", E_valA, 64'd42);
        chk("call_dstE", {60'd0, E_dstE}, 64'd4);
        chk("call_srcB", {60'd0, E_srcB}, 64'd4);
        chk("call_dstM", {60'd0, E_dstM}, 64'hF);

        // Bubble while a W write lands
        idle();
        E_bubble = 1'b1; D_icode = 4'h3; D_rB = 4'd5;
        W_dstE = 4'd6; W_valE = 64'd77;
        tick();
        chk("bubble_icode", {60'd0, E_icode}, 64'd1);
        chk("bubble_dstE",  {60'd0, E_dstE},  64'hF);
        idle();
        D_icode = 4'h6; D_rA = 4'd6; D_rB = 4'd7;
        tick();
        chk("bubble_write_landed", E_valA, 64'd77);

        // Unknown icode
        idle();
        D_icode = 4'hC; D_stat = 4'h3; D_ifun = 4'h5; D_rA = 4'd1; D_rB = 4'd2;
        #1;
        chk("unk_d_srcA", {60'd0, d_srcA}, 64'hF);
        tick();
        chk("unk_icode", {60'd0, E_icode}, 64'hC);
        chk("unk_stat",  {60'd0, E_stat},  64'h3);
        chk("unk_dstE",  {60'd0, E_dstE},  64'hF);

        // Reset mid-run while E holds an OPq
        idle();
        D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd2;
        tick();
        chk("pre_rst_icode", {60'd0, E_icode}, 64'h6);
        doReset();
        #1;
        chk("midrst_icode", {60'd0, E_icode}, 64'd1);
        chk("midrst_dstE",  {60'd0, E_dstE},  64'hF);
        tick();
        rst = 1'b0;
        idle();
        D_icode = 4'hA; D_rA = 4'd3;
        tick();
        chk("midrst_reg3", E_valA, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
                tick();
                rst = 1'b0;
            end
            D_stat   = 4'($urandom_range(0, 15));
            D_icode  = 4'($urandom_range(0, 15));
            D_ifun   = 4'($urandom_range(0, 15));
            D_rA     = 4'($urandom_range(0, 15));
            D_rB     = 4'($urandom_range(0, 15));
            D_valC   = rnd64();
            D_valP   = rnd64();
            E_bubble = ($urandom_range(0, 7) == 0);
            e_dstE   = 4'($urandom_range(0, 15));
            M_dstE   = 4'($urandom_range(0, 15));
            M_dstM   = 4'($urandom_range(0, 15));
            W_dstE   = 4'($urandom_range(0, 15));
            W_dstM   = 4'($urandom_range(0, 15));
            e_valE   = rnd64();
            M_valE   = rnd64();
            m_valM   = rnd64();
            W_valE   = rnd64();
            W_valM   = rnd64();
            tick();
        end

        @(negedge clk);
        #1;
        chkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

endmodule
